// File: rtl/wind_pattern_decoder.sv
// wind_pattern_decoder
// ---------------------------------------------------------------------------
// Receive side of the wind-direction LED link. Samples the 3-bit LED pattern
// stream, checks every pattern transition against the encoder's state graph
// and recovers the 2-bit wind status that caused it. Declares lock after
// LOCK_LEN consecutive legal transitions.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low; 0 clears all state
//   leds       in   [2:0] LED pattern sample
//   led_valid  in   leds carries a new pattern this cycle
//   w_out      out  [1:0] recovered wind status (holds between updates)
//   w_valid    out  one-cycle pulse, w_out/w_amb updated
//   w_amb      out  transition maps to several w values, w_out is the lowest
//   err        out  one-cycle pulse, illegal pattern or transition
//   locked     out  high while in LOCKED
//   err_cnt    out  [ERR_CNT_W-1:0] saturating count of err pulses
//   timeout    out  one-cycle pulse, only with WIND_DEC_TIMEOUT_EN defined
//
// Build option: define WIND_DEC_TIMEOUT_EN to add an idle counter that drops
// SYNC/LOCKED back to IDLE after TIMEOUT cycles without a sample.
// ---------------------------------------------------------------------------
module wind_pattern_decoder #(
    parameter int LOCK_LEN  = 4,
    parameter int ERR_CNT_W = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           leds,
    input  logic                 led_valid,
    output logic [1:0]           w_out,
    output logic                 w_valid,
    output logic                 w_amb,
    output logic                 err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef WIND_DEC_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    localparam int GOOD_W = $clog2(LOCK_LEN + 1);

    if (LOCK_LEN < 1 || TIMEOUT < 1) begin : g_param_check
        $error("wind_pattern_decoder: LOCK_LEN and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Pattern is one of the four encoder codes.
    function automatic logic is_code(input logic [2:0] p);
        return (p == 3'b010) || (p == 3'b101) || (p == 3'b001) || (p == 3'b100);
    endfunction

    // Transition table: returns {legal, amb, w[1:0]}. Ambiguous entries
    // report the lowest candidate w.
    function automatic logic [3:0] decode_step(input logic [2:0] prev_p,
                                               input logic [2:0] cur_p);
        case ({prev_p, cur_p})
            6'b010_101: return 4'b1_0_00;  // P0->P1
            6'b010_001: return 4'b1_0_10;  // P0->P2
            6'b010_100: return 4'b1_1_01;  // P0->P3 (01/11)
            6'b101_010: return 4'b1_0_00;  // P1->P0
            6'b101_001: return 4'b1_1_01;  // P1->P2 (01/10/11)
            6'b001_101: return 4'b1_0_00;  // P2->P1
            6'b001_100: return 4'b1_0_10;  // P2->P3
            6'b001_010: return 4'b1_1_01;  // P2->P0 (01/11)
            6'b100_101: return 4'b1_0_00;  // P3->P1
            6'b100_010: return 4'b1_0_10;  // P3->P0
            6'b100_001: return 4'b1_1_01;  // P3->P2 (01/11)
            default:    return 4'b0_0_00;
        endcase
    endfunction

    state_t                 state, state_nxt;
    logic [2:0]             prev, prev_nxt;
    logic [GOOD_W-1:0]      good, good_nxt;
    logic [1:0]             w_out_nxt;
    logic                   w_valid_nxt, w_amb_nxt, err_nxt, locked_nxt;
    logic [ERR_CNT_W-1:0]   err_cnt_nxt;
    logic [3:0]             step;
    logic                   cur_ok;

    assign step   = decode_step(prev, leds);
    assign cur_ok = is_code(leds);

`ifdef WIND_DEC_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt, idle_nxt;
    logic              timeout_nxt;
`endif

    // State register (all registered outputs update here too)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            prev    <= '0;
            good    <= '0;
            w_out   <= '0;
            w_valid <= 1'b0;
            w_amb   <= 1'b0;
            err     <= 1'b0;
            locked  <= 1'b0;
            err_cnt <= '0;
`ifdef WIND_DEC_TIMEOUT_EN
            idle_cnt <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            prev    <= prev_nxt;
            good    <= good_nxt;
            w_out   <= w_out_nxt;
            w_valid <= w_valid_nxt;
            w_amb   <= w_amb_nxt;
            err     <= err_nxt;
            locked  <= locked_nxt;
            err_cnt <= err_cnt_nxt;
`ifdef WIND_DEC_TIMEOUT_EN
            idle_cnt <= idle_nxt;
            timeout  <= timeout_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        good_nxt  = good;
`ifdef WIND_DEC_TIMEOUT_EN
        idle_nxt    = '0;
        timeout_nxt = 1'b0;
`endif
        if (led_valid) begin
            if (state == ST_IDLE) begin
                if (cur_ok) begin
                    prev_nxt  = leds;
                    good_nxt  = '0;
                    state_nxt = ST_SYNC;
                end
            end else if (step[3]) begin
                prev_nxt  = leds;
                good_nxt  = (good == GOOD_W'(LOCK_LEN)) ? good : good + 1'b1;
                state_nxt = (good_nxt == GOOD_W'(LOCK_LEN)) ? ST_LOCKED : ST_SYNC;
            end else begin
                // An illegal but well-formed code still serves as the new
                // reference, so resync does not need to go through IDLE.
                good_nxt = '0;
                if (cur_ok) begin
                    prev_nxt  = leds;
                    state_nxt = ST_SYNC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        end
`ifdef WIND_DEC_TIMEOUT_EN
        else if (state != ST_IDLE) begin
            if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                state_nxt   = ST_IDLE;
                good_nxt    = '0;
                timeout_nxt = 1'b1;
            end else begin
                idle_nxt = idle_cnt + 1'b1;
            end
        end
`endif
    end

    // Output logic
    always_comb begin
        w_valid_nxt = 1'b0;
        err_nxt     = 1'b0;
        w_out_nxt   = w_out;
        w_amb_nxt   = w_amb;
        err_cnt_nxt = err_cnt;
        if (led_valid) begin
            if (state == ST_IDLE) begin
                err_nxt = !cur_ok;
            end else if (step[3]) begin
                w_valid_nxt = 1'b1;
                w_amb_nxt   = step[2];
                w_out_nxt   = step[1:0];
            end else begin
                err_nxt = 1'b1;
            end
        end
        if (err_nxt && (err_cnt != '1)) begin
            err_cnt_nxt = err_cnt + 1'b1;
        end
        locked_nxt = (state_nxt == ST_LOCKED);
    end

endmodule

// File: tb/tb_wind_pattern_decoder.sv
// Testbench for wind_pattern_decoder (default parameters).
// Stimulus pushes the expected response of every sample that produces a
// w_valid or err pulse; the monitor pops and compares on each such pulse.
module tb_wind_pattern_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] leds;
    logic       led_valid;
    logic [1:0] w_out;
    logic       w_valid, w_amb, err, locked;
    logic [7:0] err_cnt;
`ifdef WIND_DEC_TIMEOUT_EN
    logic       timeout;
`endif

    wind_pattern_decoder dut (
`ifdef WIND_DEC_TIMEOUT_EN
        .timeout  (timeout),
`endif
        .clk      (clk),
        .reset    (reset),
        .leds     (leds),
        .led_valid(led_valid),
        .w_out    (w_out),
        .w_valid  (w_valid),
        .w_amb    (w_amb),
        .err      (err),
        .locked   (locked),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [1:0] w;
        logic       amb;
        logic       lk;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic [1:0] last_w   = 2'b00;
    logic       last_amb = 1'b0;
    int         exp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One sample, held for exactly one clock edge.
    task automatic send(input logic [2:0] p);
        leds      = p;
        led_valid = 1'b1;
        @(posedge clk);
        #1;
        led_valid = 1'b0;
    endtask

    // Sample expected to decode as w/amb.
    task automatic sw(input logic [2:0] p, input logic [1:0] w, input logic amb, input logic lk);
        exp_t e;
        e.is_err = 1'b0; e.w = w; e.amb = amb; e.lk = lk; e.cnt = 8'(exp_cnt);
        last_w = w; last_amb = amb;
        q.push_back(e);
        send(p);
    endtask

    // Sample expected to raise err; w_out/w_amb hold.
    task automatic se(input logic [2:0] p, input logic lk);
        exp_t e;
        if (exp_cnt < 255) exp_cnt++;
        e.is_err = 1'b1; e.w = last_w; e.amb = last_amb; e.lk = lk; e.cnt = 8'(exp_cnt);
        q.push_back(e);
        send(p);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (w_valid || err) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious: w_valid=%0b err=%0b with nothing expected at %0t",
                         w_valid, err, $time);
            end else begin
                e = q.pop_front();
                chk("kind",    32'({w_valid, err}), 32'({~e.is_err, e.is_err}));
                chk("w_out",   32'(w_out),   32'(e.w));
                chk("w_amb",   32'(w_amb),   32'(e.amb));
                chk("locked",  32'(locked),  32'(e.lk));
                chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        leds      = 3'b000;
        led_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_out",   32'(w_out),   0);
        chk("rst_w_valid", 32'(w_valid), 0);
        chk("rst_w_amb",   32'(w_amb),   0);
        chk("rst_err",     32'(err),     0);
        chk("rst_locked",  32'(locked),  0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Acquire lock on alternating P0/P1
        send(3'b010);
        sw(3'b101, 2'b00, 1'b0, 1'b0);
        sw(3'b010, 2'b00, 1'b0, 1'b0);
        sw(3'b101, 2'b00, 1'b0, 1'b0);
        sw(3'b010, 2'b00, 1'b0, 1'b1);

        // Walk P0->P2->P3->P0 then an ambiguous P0->P3
        sw(3'b001, 2'b10, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        sw(3'b100, 2'b10, 1'b0, 1'b1);
        sw(3'b010, 2'b10, 1'b0, 1'b1);
        sw(3'b100, 2'b01, 1'b1, 1'b1);

        // P3->P1, then illegal P1->P3, then P3->P2 (ambiguous)
        sw(3'b101, 2'b00, 1'b0, 1'b1);
        se(3'b100, 1'b0);
        sw(3'b001, 2'b01, 1'b1, 1'b0);

        // Relock, then invalid code while locked drops to IDLE
        sw(3'b101, 2'b00, 1'b0, 1'b0);
        sw(3'b010, 2'b00, 1'b0, 1'b0);
        sw(3'b101, 2'b00, 1'b0, 1'b1);
        se(3'b111, 1'b0);
        send(3'b010);
        sw(3'b101, 2'b00, 1'b0, 1'b0);

        // Invalid code in SYNC, invalid code in IDLE, then re-reference
        se(3'b011, 1'b0);
        se(3'b000, 1'b0);
        send(3'b101);
        sw(3'b010, 2'b00, 1'b0, 1'b0);

        // Self-transitions until err_cnt saturates
        for (int i = 0; i < 300; i++) se(3'b010, 1'b0);
        sw(3'b101, 2'b00, 1'b0, 1'b0);
        sw(3'b001, 2'b01, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_w_out",   32'(w_out),   0);
        chk("arst_w_amb",   32'(w_amb),   0);
        chk("arst_err_cnt", 32'(err_cnt), 0);
        chk("arst_locked",  32'(locked),  0);
        chk("arst_w_valid", 32'(w_valid), 0);
        chk("arst_err",     32'(err),     0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        last_w   = 2'b00;
        last_amb = 1'b0;
        exp_cnt  = 0;
        send(3'b101);
        sw(3'b010, 2'b00, 1'b0, 1'b0);

`ifdef WIND_DEC_TIMEOUT_EN
        begin
            int n;
            logic seen;
            sw(3'b101, 2'b00, 1'b0, 1'b0);
            sw(3'b010, 2'b00, 1'b0, 1'b0);
            sw(3'b101, 2'b00, 1'b0, 1'b1);
            n = 0;
            while (timeout !== 1'b1 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("timeout_cycles", 32'(n), 16);
            chk("timeout_locked", 32'(locked), 0);

            send(3'b010);
            sw(3'b101, 2'b00, 1'b0, 1'b0);
            sw(3'b010, 2'b00, 1'b0, 1'b0);
            sw(3'b101, 2'b00, 1'b0, 1'b0);
            sw(3'b010, 2'b00, 1'b0, 1'b1);
            seen = 1'b0;
            for (int i = 0; i < 14; i++) begin
                @(posedge clk);
                #1;
                if (timeout === 1'b1) seen = 1'b1;
            end
            sw(3'b101, 2'b00, 1'b0, 1'b1);
            for (int i = 0; i < 14; i++) begin
                @(posedge clk);
                #1;
                if (timeout === 1'b1) seen = 1'b1;
            end
            chk("no_timeout", 32'(seen), 0);
            chk("no_timeout_locked", 32'(locked), 1);
        end
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wind_pattern_decoder.md
Name: wind_pattern_decoder

Overview:
- Receive side of the wind-direction LED link: samples the 3-bit LED pattern stream produced by the wind-direction state machine and recovers the 2-bit wind status w that caused each pattern transition.
- Tracks the previous pattern, validates every transition against the encoder's state graph, reports decode/ambiguity/error status, and declares lock after a run of legal transitions.
- Sits between the LED pattern source (or captured pins) and downstream wind logging/display logic.

Parameters:
- LOCK_LEN, 4, consecutive legal transitions required to enter LOCKED (min 1).
- ERR_CNT_W, 8, width of saturating illegal-transition counter.
- TIMEOUT, 16, idle-sample cycle limit used only when WIND_DEC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- leds  in  3  LED pattern sample.
- led_valid  in  1  leds holds a new pattern this cycle (one sample per pulse).
- w_out  out  2  recovered wind status.
- w_valid  out  1  one-cycle pulse: w_out updated.
- w_amb  out  1  qualifies w_valid: transition maps to more than one w; w_out is lowest candidate.
- err  out  1  one-cycle pulse: illegal pattern or transition.
- locked  out  1  high while in LOCKED.
- err_cnt  out  ERR_CNT_W  saturating count of err pulses.

Behaviour:
- Codes: P0=010, P1=101, P2=001, P3=100; any other 3-bit value is invalid.
- State machine: IDLE (no reference pattern), SYNC (reference held, good-run counter < LOCK_LEN), LOCKED.
- Reset (reset=0): state=IDLE, prev cleared, good-run=0, w_out=00, w_valid=0, w_amb=0, err=0, locked=0, err_cnt=0.
- IDLE: valid code -> store as prev, go SYNC, no w_valid. Invalid code -> err pulse, stay IDLE.
- SYNC/LOCKED legal transitions (prev -> cur : w_out, w_amb):
  - P0->P1: 00, 0. P0->P2: 10, 0. P0->P3: 01, 1 (01/11).
  - P1->P0: 00, 0. P1->P2: 01, 1 (01/10/11).
  - P2->P1: 00, 0. P2->P3: 10, 0. P2->P0: 01, 1 (01/11).
  - P3->P1: 00, 0. P3->P0: 10, 0. P3->P2: 01, 1 (01/11).
- Illegal: any self-transition (Px->Px), P1->P3, or an invalid code.
- Legal transition: prev<=cur, w_out/w_amb registered, w_valid pulse. Latency is 1 cycle: outputs appear the cycle after the led_valid sample edge. Good-run increments and saturates at LOCK_LEN. SYNC goes to LOCKED when the count reaches LOCK_LEN.
- Illegal transition (SYNC or LOCKED): err pulse, no w_valid, good-run=0, state=SYNC. prev<=cur if cur is a valid code; otherwise state=IDLE.
- err_cnt increments on every err pulse and holds at all-ones.
- led_valid=0: no state change. w_valid and err are 0. w_out and w_amb hold their last values.
- locked is a registered decode of state. It drops in the same cycle err pulses.
- Reset asserted mid-operation: immediate return to reset values. First sample after release is treated as in IDLE.

Optional Feature:
- WIND_DEC_TIMEOUT_EN defined: an idle counter counts cycles with led_valid=0 while in SYNC/LOCKED, and any led_valid clears it. On reaching TIMEOUT: state=IDLE, locked=0, good-run=0, and a timeout output port (1-bit, one-cycle pulse) is added. Timeout does not increment err_cnt.
- Macro undefined: no idle counter, no timeout port. SYNC/LOCKED are held indefinitely without samples.

Test Plan:
- Reset, then led_valid samples 010,101,010,101,010 -> w_valid x4, w_out=00, w_amb=0, locked=1 one cycle after 5th sample, err_cnt=0.
- From lock at prev=010, samples 001,100,010 -> w_out 10,10,10, w_amb=0. Then 100 -> w_out=01, w_amb=1.
- Locked at prev=101, sample 100 -> err pulse, locked=0, err_cnt=1, no w_valid. Then 001 -> w_out=01, w_amb=1, state SYNC.
- Sample 111 while locked -> err pulse, state IDLE. Next 010 -> no w_valid. Next 101 -> w_valid, w_out=00.
- Force 300 illegal self-transitions with ERR_CNT_W=8 -> err_cnt saturates at 255. Drop reset mid-stream -> all outputs 0 asynchronously.
- WIND_DEC_TIMEOUT_EN, TIMEOUT=16: lock, then 16 cycles led_valid=0 -> timeout pulse, locked=0. Repeat with a sample at cycle 15 -> no timeout.
